// File: rtl/fixed_point_pkg.sv
// Shared definitions for the fixed-point pow arbiter: operand width derivation
// and the controller FSM state encoding.
package fixed_point_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ISSUE   = 2'd1;
   localparam logic [1:0] ST_WAIT    = 2'd2;
   localparam logic [1:0] ST_RESPOND = 2'd3;

   function automatic int number_width(input int int_bits, input int frac_bits);
      return int_bits + frac_bits;
   endfunction

endpackage

// File: rtl/round_robin_picker.sv
// Combinational round-robin picker: first set request bit scanning upward
// from last_grant+1, wrapping modulo NUM_REQUESTERS.
module round_robin_picker #(
   parameter int NUM_REQUESTERS = 4,
   localparam int IDX_W = $clog2(NUM_REQUESTERS)
) (
   input  logic [NUM_REQUESTERS-1:0] req_masked_i,
   input  logic [IDX_W-1:0]          last_grant_i,
   output logic                      grant_valid_o,
   output logic [IDX_W-1:0]          grant_index_o
);

   int idx;

   // Scan offsets from farthest to nearest so the nearest hit overwrites.
   always_comb begin
      grant_valid_o = 1'b0;
      grant_index_o = '0;
      idx           = 0;
      for (int k = NUM_REQUESTERS; k >= 1; k--) begin
         idx = (int'(last_grant_i) + k) % NUM_REQUESTERS;
         if (req_masked_i[IDX_W'(idx)]) begin
            grant_valid_o = 1'b1;
            grant_index_o = IDX_W'(idx);
         end
      end
   end

endmodule

// File: rtl/fixed_point_pow_arbiter.sv
// Round-robin controller sharing one fixed_point_pow unit between several
// clients. Optional WAIT watchdog: define FIXED_POINT_POW_ARBITER_TIMEOUT_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | arbitrate among unmasked requests, latch operands
// ISSUE   | pow_start high for this single cycle
// WAIT    | wait for pow_done (first cycle blanked, done may be stale)
// RESPOND | req_done[cur] pulse with resp_result / resp_error
module fixed_point_pow_arbiter
   import fixed_point_pkg::*;
#(
   parameter int INTEGER_PART_WIDTH    = 3,
   parameter int FRACTIONAL_PART_WIDTH = 2,
   parameter int NUM_REQUESTERS        = 4,
   parameter int TIMEOUT_CYCLES        = 64,
   localparam int NUMBER_WIDTH = number_width(INTEGER_PART_WIDTH, FRACTIONAL_PART_WIDTH),
   localparam int IDX_W        = $clog2(NUM_REQUESTERS)
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic [NUM_REQUESTERS-1:0]              req,
   input  logic [NUM_REQUESTERS*NUMBER_WIDTH-1:0] req_a,
   input  logic [NUM_REQUESTERS*NUMBER_WIDTH-1:0] req_b,
   output logic [NUM_REQUESTERS-1:0]              req_done,
   output logic [NUMBER_WIDTH-1:0]                resp_result,
   output logic                                   resp_error,
   output logic                                   busy,
   output logic                                   pow_start,
   output logic [NUMBER_WIDTH-1:0]                pow_a,
   output logic [NUMBER_WIDTH-1:0]                pow_b,
   input  logic                                   pow_done,
   input  logic [NUMBER_WIDTH-1:0]                pow_result
);

   logic [1:0]                state_q, state_d;
   logic [IDX_W-1:0]          cur_q, cur_d;
   logic [IDX_W-1:0]          last_grant_q, last_grant_d;
   logic [NUMBER_WIDTH-1:0]   pow_a_q, pow_a_d, pow_b_q, pow_b_d;
   logic [NUMBER_WIDTH-1:0]   resp_result_q, resp_result_d;
   logic [NUM_REQUESTERS-1:0] req_done_q, req_done_d;
   logic                      pow_start_q, pow_start_d;
   logic                      resp_error_q, resp_error_d;
   logic                      busy_q, busy_d;
   logic                      blank_q, blank_d;
   logic                      mask_q, mask_d;

   logic [NUM_REQUESTERS-1:0] cur_onehot;
   logic [NUM_REQUESTERS-1:0] req_masked;
   logic                      grant_valid;
   logic [IDX_W-1:0]          grant_index;

`ifdef FIXED_POINT_POW_ARBITER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

   assign cur_onehot = NUM_REQUESTERS'(1) << cur_q;
   // The client just served is hidden for one IDLE cycle so it can drop req.
   assign req_masked = req & ~(mask_q ? cur_onehot : '0);

   round_robin_picker #(.NUM_REQUESTERS(NUM_REQUESTERS)) u_picker (
      .req_masked_i (req_masked),
      .last_grant_i (last_grant_q),
      .grant_valid_o(grant_valid),
      .grant_index_o(grant_index)
   );

   // Next-state and registered-output logic for the sequencing FSM.
   always_comb begin
      state_d       = state_q;
      cur_d         = cur_q;
      last_grant_d  = last_grant_q;
      pow_a_d       = pow_a_q;
      pow_b_d       = pow_b_q;
      resp_result_d = resp_result_q;
      resp_error_d  = resp_error_q;
      blank_d       = blank_q;
      mask_d        = mask_q;
      pow_start_d   = 1'b0;
      req_done_d    = '0;
`ifdef FIXED_POINT_POW_ARBITER_TIMEOUT_EN
      wait_cnt_d    = wait_cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            mask_d = 1'b0;
            if (grant_valid) begin
               cur_d        = grant_index;
               last_grant_d = grant_index;
               pow_a_d      = req_a[int'(grant_index)*NUMBER_WIDTH +: NUMBER_WIDTH];
               pow_b_d      = req_b[int'(grant_index)*NUMBER_WIDTH +: NUMBER_WIDTH];
               pow_start_d  = 1'b1;
               state_d      = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            blank_d = 1'b1;
`ifdef FIXED_POINT_POW_ARBITER_TIMEOUT_EN
            wait_cnt_d = CNT_W'(TIMEOUT_CYCLES - 1);
`endif
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            blank_d = 1'b0;
`ifdef FIXED_POINT_POW_ARBITER_TIMEOUT_EN
            if (wait_cnt_q != '0) wait_cnt_d = wait_cnt_q - CNT_W'(1);
`endif
            if (!blank_q && pow_done) begin
               resp_result_d = pow_result;
               resp_error_d  = 1'b0;
               req_done_d    = cur_onehot;
               state_d       = ST_RESPOND;
            end
`ifdef FIXED_POINT_POW_ARBITER_TIMEOUT_EN
            else if (wait_cnt_q == '0) begin
               resp_result_d = '0;
               resp_error_d  = 1'b1;
               req_done_d    = cur_onehot;
               state_d       = ST_RESPOND;
            end
`endif
         end
         default: begin
            mask_d  = 1'b1;
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         cur_q         <= '0;
         last_grant_q  <= IDX_W'(NUM_REQUESTERS - 1);
         pow_a_q       <= '0;
         pow_b_q       <= '0;
         resp_result_q <= '0;
         resp_error_q  <= 1'b0;
         req_done_q    <= '0;
         pow_start_q   <= 1'b0;
         busy_q        <= 1'b0;
         blank_q       <= 1'b0;
         mask_q        <= 1'b0;
`ifdef FIXED_POINT_POW_ARBITER_TIMEOUT_EN
         wait_cnt_q    <= '0;
`endif
      end else begin
         state_q       <= state_d;
         cur_q         <= cur_d;
         last_grant_q  <= last_grant_d;
         pow_a_q       <= pow_a_d;
         pow_b_q       <= pow_b_d;
         resp_result_q <= resp_result_d;
         resp_error_q  <= resp_error_d;
         req_done_q    <= req_done_d;
         pow_start_q   <= pow_start_d;
         busy_q        <= busy_d;
         blank_q       <= blank_d;
         mask_q        <= mask_d;
`ifdef FIXED_POINT_POW_ARBITER_TIMEOUT_EN
         wait_cnt_q    <= wait_cnt_d;
`endif
      end
   end

   assign req_done    = req_done_q;
   assign resp_result = resp_result_q;
   assign resp_error  = resp_error_q;
   assign busy        = busy_q;
   assign pow_start   = pow_start_q;
   assign pow_a       = pow_a_q;
   assign pow_b       = pow_b_q;

endmodule

// File: tb/tb_fixed_point_pow_arbiter.sv
// Self-checking bench for fixed_point_pow_arbiter with a behavioural pow unit
// model and an expected-response scoreboard queue.
module tb_fixed_point_pow_arbiter;

   localparam int NW = 5;
   localparam int NR = 4;

   logic            clk, rst_n;
   logic [NR-1:0]   req, req_done;
   logic [NR*NW-1:0] req_a, req_b;
   logic [NW-1:0]   resp_result, pow_a, pow_b, pow_result;
   logic            resp_error, busy, pow_start, pow_done;

   fixed_point_pow_arbiter #(
      .INTEGER_PART_WIDTH(3), .FRACTIONAL_PART_WIDTH(2),
      .NUM_REQUESTERS(NR), .TIMEOUT_CYCLES(8)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b),
      .req_done(req_done), .resp_result(resp_result), .resp_error(resp_error),
      .busy(busy), .pow_start(pow_start), .pow_a(pow_a), .pow_b(pow_b),
      .pow_done(pow_done), .pow_result(pow_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          client;
      logic [4:0]  a;
      logic [4:0]  b;
      logic [4:0]  res;
      logic        err;
   } exp_t;

   typedef struct {
      int          client;
      logic [4:0]  a;
      logic [4:0]  b;
      int          lat;
      logic [4:0]  exp_res;
      int          exp_lat;
   } vec_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   n_starts = 0;
   int   last_done_cyc = 0;
   int   last_start_cyc = 0;
   int   gap_at_start = 0;

   int   lat = 2;
   bit   stale_mode = 0;
   bit   never_done = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input bit ok, input string name, input longint act, input longint exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [4:0] pow_model(input logic [4:0] a, input logic [4:0] b);
      int p;
      p = int'($signed(a)) * int'($signed(b));
      p = p >>> 2;
      return p[4:0];
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_ops(input int c, input logic [4:0] a, input logic [4:0] b);
      req_a[c*NW +: NW] = a;
      req_b[c*NW +: NW] = b;
   endtask

   task automatic push_exp(input int c, input logic [4:0] a, input logic [4:0] b);
      exp_t e;
      e.client = c; e.a = a; e.b = b; e.res = pow_model(a, b); e.err = 1'b0;
      q.push_back(e);
   endtask

   // Waits for the scoreboard to drain; clients drop req on their own done
   // pulse, or all drop together after hold_ops pulses.
   task automatic run_until_empty(input int max_cyc, input int hold_ops, input string name);
      int n, seen;
      n = 0; seen = 0;
      while (q.size() != 0 && n < max_cyc) begin
         @(posedge clk); #1; n++;
         if (req_done != '0) begin
            seen++;
            if (hold_ops == 0) req = req & ~req_done;
            else if (seen >= hold_ops) req = '0;
         end
      end
      check(q.size() == 0, name, q.size(), 0);
      if (q.size() != 0) q.delete();
      req = '0;
      tick(2);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      q.delete();
      tick(2);
      rst_n = 1'b1;
      tick(1);
   endtask

   // Behavioural pow unit: done level rises lat cycles after start and stays
   // high until the next start (or two cycles longer in stale mode).
   initial begin : pow_unit
      int k;
      logic [4:0] pend;
      pow_done = 1'b0; pow_result = '0; k = -1; pend = '0;
      forever begin
         @(posedge clk); #1;
         if (!rst_n) begin
            pow_done = 1'b0; pow_result = '0; k = -1;
         end else begin
            if (pow_start) begin
               k = 0;
               pend = pow_model(pow_a, pow_b);
               if (!stale_mode) pow_done = 1'b0;
            end else if (k >= 0) begin
               k++;
            end
            if (k == 2 && stale_mode) pow_done = 1'b0;
            if (k >= 1 && k == lat && !never_done) begin
               pow_done = 1'b1; pow_result = pend; k = -1;
            end
         end
      end
   end

   // Scoreboard monitor, sampling on the falling edge.
   initial begin : monitor
      exp_t e;
      bit prev_start;
      prev_start = 0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (pow_start) begin
               n_starts++;
               gap_at_start = cyc - last_done_cyc;
               last_start_cyc = cyc;
               check(!prev_start, "start_pulse_width", 2, 1);
               if (q.size() == 0) begin
                  check(1'b0, "unexpected_start", 1, 0);
               end else begin
                  check(pow_a == q[0].a, "pow_a_at_start", pow_a, q[0].a);
                  check(pow_b == q[0].b, "pow_b_at_start", pow_b, q[0].b);
               end
            end
            if (req_done != '0) begin
               last_done_cyc = cyc;
               if (q.size() == 0) begin
                  check(1'b0, "unexpected_req_done", req_done, 0);
               end else begin
                  e = q.pop_front();
                  check(req_done == (NR'(1) << e.client), "req_done_onehot", req_done, NR'(1) << e.client);
                  check(resp_result == e.res, "resp_result", resp_result, e.res);
                  check(resp_error == e.err, "resp_error", resp_error, e.err);
                  check(pow_a == e.a && pow_b == e.b, "operands_held", {pow_a, pow_b}, {e.a, e.b});
               end
            end
            prev_start = pow_start;
         end else begin
            prev_start = 0;
         end
      end
   end

   initial begin : main
      vec_t vecs[6];
      int t0, s0, n;
      exp_t e;

      vecs[0] = '{client: 0, a: 5'd8,  b: 5'd8,  lat: 3, exp_res: 5'd16, exp_lat: 5};
      vecs[1] = '{client: 1, a: 5'd6,  b: 5'd4,  lat: 1, exp_res: 5'd6,  exp_lat: 4};
      vecs[2] = '{client: 2, a: 5'd28, b: 5'd8,  lat: 2, exp_res: 5'd24, exp_lat: 4};
      vecs[3] = '{client: 3, a: 5'd3,  b: 5'd5,  lat: 5, exp_res: 5'd3,  exp_lat: 7};
      vecs[4] = '{client: 1, a: 5'd26, b: 5'd26, lat: 4, exp_res: 5'd9,  exp_lat: 6};
      vecs[5] = '{client: 0, a: 5'd7,  b: 5'd4,  lat: 1, exp_res: 5'd7,  exp_lat: 4};

      rst_n = 1'b0; req = '0; req_a = '0; req_b = '0;
      @(negedge clk);
      check(busy == 1'b0, "reset_busy", busy, 0);
      check(req_done == '0, "reset_req_done", req_done, 0);
      check(pow_start == 1'b0, "reset_pow_start", pow_start, 0);
      check(resp_result == '0 && resp_error == 1'b0, "reset_resp", {resp_result, resp_error}, 0);
      check(pow_a == '0 && pow_b == '0, "reset_pow_ops", {pow_a, pow_b}, 0);
      tick(2);
      rst_n = 1'b1;
      tick(1);

      // Single-client transactions from the vector table.
      for (int i = 0; i < 6; i++) begin
         lat = vecs[i].lat;
         set_ops(vecs[i].client, vecs[i].a, vecs[i].b);
         e.client = vecs[i].client; e.a = vecs[i].a; e.b = vecs[i].b;
         e.res = vecs[i].exp_res; e.err = 1'b0;
         q.push_back(e);
         s0 = n_starts;
         t0 = cyc;
         req[vecs[i].client] = 1'b1;
         check(busy == 1'b0, "idle_before_req", busy, 0);
         tick(2);
         check(busy == 1'b1, "busy_in_op", busy, 1);
         set_ops(vecs[i].client, ~vecs[i].a, ~vecs[i].b);
         run_until_empty(40, 0, "vec_complete");
         check(last_done_cyc - t0 == vecs[i].exp_lat, "vec_latency", last_done_cyc - t0, vecs[i].exp_lat);
         check(n_starts - s0 == 1, "vec_start_count", n_starts - s0, 1);
      end

      // Stale done level from the previous op must be ignored in the blank cycle.
      stale_mode = 1; lat = 4;
      set_ops(1, 5'd5, 5'd4);
      push_exp(1, 5'd5, 5'd4);
      req[1] = 1'b1;
      run_until_empty(40, 0, "stale_complete");
      stale_mode = 0;

      // All four clients at once after reset: order 0,1,2,3, back-to-back.
      do_reset();
      lat = 1;
      for (int c = 0; c < NR; c++) begin
         set_ops(c, 5'(c + 4), 5'(9 - c));
         push_exp(c, 5'(c + 4), 5'(9 - c));
      end
      req = 4'hF;
      run_until_empty(80, 0, "all4_complete");
      check(gap_at_start == 2, "back_to_back_gap", gap_at_start, 2);

      // Clients 0 and 2 both hold req continuously: strict alternation.
      lat = 2;
      set_ops(0, 5'd4, 5'd4);
      set_ops(2, 5'd10, 5'd28);
      for (int j = 0; j < 3; j++) begin
         push_exp(0, 5'd4, 5'd4);
         push_exp(2, 5'd10, 5'd28);
      end
      req[0] = 1'b1; req[2] = 1'b1;
      run_until_empty(120, 6, "alternate_complete");

      // Client 2 alone holding req: masked IDLE cycle before re-grant.
      push_exp(2, 5'd10, 5'd28);
      push_exp(2, 5'd10, 5'd28);
      req[2] = 1'b1;
      run_until_empty(60, 2, "regrant_complete");
      check(gap_at_start == 3, "regrant_mask_gap", gap_at_start, 3);

      // Reset during WAIT: everything clears, client 0 first afterwards.
      never_done = 1;
      set_ops(1, 5'd9, 5'd2);
      push_exp(1, 5'd9, 5'd2);
      req[1] = 1'b1;
      n = 0;
      while (!pow_start && n < 20) begin tick(1); n++; end
      check(pow_start == 1'b1, "reset_test_start_seen", pow_start, 1);
      tick(2);
      rst_n = 1'b0;
      @(negedge clk);
      check(busy == 1'b0 && req_done == '0 && pow_start == 1'b0, "midop_reset_ctrl",
            {busy, req_done, pow_start}, 0);
      check(resp_result == '0 && resp_error == 1'b0 && pow_a == '0 && pow_b == '0,
            "midop_reset_data", {resp_result, resp_error, pow_a, pow_b}, 0);
      q.delete();
      tick(2);
      never_done = 0; lat = 2;
      set_ops(0, 5'd12, 5'd4);
      push_exp(0, 5'd12, 5'd4);
      push_exp(1, 5'd9, 5'd2);
      req[0] = 1'b1;
      rst_n = 1'b1;
      run_until_empty(60, 0, "post_reset_complete");

`ifdef FIXED_POINT_POW_ARBITER_TIMEOUT_EN
      // Watchdog: pow_done never comes, error response after 8 WAIT cycles.
      never_done = 1;
      set_ops(3, 5'd6, 5'd6);
      e.client = 3; e.a = 5'd6; e.b = 5'd6; e.res = '0; e.err = 1'b1;
      q.push_back(e);
      req[3] = 1'b1;
      run_until_empty(60, 0, "timeout_complete");
      check(last_done_cyc - last_start_cyc == 9, "timeout_latency", last_done_cyc - last_start_cyc, 9);
      never_done = 0; lat = 2;
      set_ops(0, 5'd8, 5'd6);
      push_exp(0, 5'd8, 5'd6);
      req[0] = 1'b1;
      run_until_empty(40, 0, "after_timeout_complete");
`endif

      tick(3);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL global_timeout: got %0d expected 0", 1);
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1);
   end

endmodule
